seq_divider: RTL and testbench

- Iterative unsigned integer divider: the inverse operator to the team's pipelined Wallace multiplier, for the same datapath.
- Accepts one dividend/divisor pair via a valid/ready handshake.
- Computes quotient and remainder with a restoring shift-subtract algorithm, one quotient bit per clock.
- Holds the result under an output valid/ready handshake until it is consumed.

---
 rtl/seq_divider.sv | 92 +++++++++
 tb/tb_seq_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, valid/ready in and out.
// A zero divisor short-circuits to an all-ones quotient with the dividend as remainder.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic             r_load;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_neg;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // Trial subtraction on the shifted {R,Q}; a borrow means restore R and shift in a 0.
  assign w_shift   = {r_rem, r_q[WIDTH-1]};
  assign w_neg     = (w_shift < {2'b00, r_div});
  assign w_diff    = w_shift[WIDTH:0] - {1'b0, r_div};
  assign w_rem_nxt = w_neg ? w_shift[WIDTH:0] : w_diff;
  assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_neg};

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_load      <= 1'b0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_rem   <= '0;
          r_q     <= dividend;
          r_div   <= divisor;
          r_load  <= 1'b1;
          r_state <= BUSY;
        end
        BUSY: if (r_load) begin
          // Load edge: resolve divide-by-zero, otherwise arm the iteration counter.
          r_load <= 1'b0;
          if (r_div == '0) begin
            quotient    <= '1;
            remainder   <= r_q;
            div_by_zero <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt       <= CW'(WIDTH);
            div_by_zero <= 1'b0;
          end
        end else begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            quotient  <= w_q_nxt;
            remainder <= w_rem_nxt[WIDTH-1:0];
            r_state   <= DONE;
          end
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes model results, negedge monitor pops and compares.
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          first;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   edges = 0;
  bit   force_stall = 1'b0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at edge %0d", nm, act, exp, edges);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc_edge);
    exp_t e;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.z = 1'b1; e.first = acc_edge + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0; e.first = acc_edge + 33;
    end
    return e;
  endfunction

  // Consumer: random backpressure unless a stall is forced.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  bit          prev_v  = 1'b0;
  bit          hs_pend = 1'b0;
  logic [31:0] last_q;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      hs_pend = 1'b0;
    end else begin
      if (hs_pend) begin
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_q_held", quotient, last_q);
        hs_pend = 1'b0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!prev_v) chk("latency", 32'(edges), 32'(sb[0].first));
          chk("quotient", quotient, sb[0].q);
          chk("remainder", remainder, sb[0].r);
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, sb[0].z});
          chk("done_in_ready", {31'd0, in_ready}, 32'd0);
          if (out_ready) begin
            last_q = sb[0].q;
            void'(sb.pop_front());
            hs_pend = 1'b1;
          end
        end
      end
      prev_v = out_valid;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push, input bit junk);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1; dividend = a; divisor = b;
    if (push) sb.push_back(model(a, b, edges + 1));
    @(posedge clk); #1;
    chk("in_ready_falls", {31'd0, in_ready}, 32'd0);
    if (junk) begin
      repeat (4) begin
        in_valid = 1'($urandom_range(0, 1)); dividend = $urandom; divisor = $urandom;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    issue(32'd100, 32'd7, 1, 1);
    issue(32'hDEFE_FEFE, 32'd2, 1, 0);
    issue(32'hFFFF_FFFF, 32'd1, 1, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    issue(32'd3, 32'd10, 1, 0);
    issue(32'd0, 32'd5, 1, 0);
    issue(32'd5, 32'd0, 1, 0);
    issue(32'd100, 32'd7, 1, 0);
    drain();

    // Backpressure: hold the result while junk operands are toggled in
    force_stall = 1'b1;
    issue(32'h1234_5678, 32'h0000_1234, 1, 1);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("stall_reach_done", {31'd0, out_valid}, 32'd1);
    repeat (10) begin
      in_valid = 1'($urandom_range(0, 1)); dividend = $urandom; divisor = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    force_stall = 1'b0;
    drain();

    // Asynchronous reset mid-division
    issue(32'd100, 32'd7, 0, 0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(32'd100, 32'd7, 1, 0);
    drain();

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      issue(a, b, 1, (b != 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
